cpu_boot_ctrl: RTL



---
 rtl/cpu_boot_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: host-side sequencer that loads, runs and dumps the pipelined RISC-V cpu
//
// Ports:
//   clk, srst                 clock and synchronous active-high reset
//   start                     session start pulse (honoured in IDLE/DONE only)
//   run_cycles, dump_words    session lengths, latched on an accepted start
//   s_valid/s_ready/s_data/s_last   load stream (instruction phase, then data phase)
//   m_valid/m_ready/m_data    dump stream of data-memory words
//   imem_*                    cpu instruction-memory external write port
//   dmem_*                    cpu data-memory external read/write port
//   cpu_arst_n, cpu_enable    cpu reset and clock-enable control
//   busy, done, ovf_err       session status; ovf_err is sticky until the next start
module cpu_boot_ctrl #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic [CNT_W-1:0] dump_words,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic [63:0]      imem_addr,
    output logic             imem_wen,
    output logic [31:0]      imem_wdata,
    output logic [63:0]      dmem_addr,
    output logic             dmem_wen,
    output logic             dmem_ren,
    output logic [63:0]      dmem_wdata,
    input  logic [63:0]      dmem_rdata,
    output logic             cpu_arst_n,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic             ovf_err
);
    localparam int IAW = IMEM_DEPTH > 1 ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = DMEM_DEPTH > 1 ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [IAW-1:0] I_LAST = IAW'(IMEM_DEPTH - 1);
    localparam logic [DAW-1:0] D_LAST = DAW'(DMEM_DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_I, LOAD_D, SETTLE, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] run_q, dump_q, run_cnt, dump_cnt;
    logic [IAW-1:0]   i_idx;
    logic [DAW-1:0]   d_idx, j_idx;
    logic [63:0]      wr_addr;
    logic             acc, go, ovf_hit;

    assign acc = s_valid & s_ready;
    assign go  = start & (state == IDLE || state == DONE);
    // a phase's final slot taken without s_last closes the phase and flags overflow
    assign ovf_hit = acc & ~s_last & (state == LOAD_I ? i_idx == I_LAST : d_idx == D_LAST);

    always_ff @(posedge clk) begin
        if (srst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        dmem_ren   = 1'b0;
        dmem_addr  = wr_addr;
        cpu_enable = 1'b0;
        cpu_arst_n = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cpu_arst_n = 1'b0;
                busy       = 1'b0;
                state_nx   = start ? LOAD_I : IDLE;
            end
            LOAD_I: begin
                cpu_arst_n = 1'b0;
                s_ready    = 1'b1;
                state_nx   = s_valid && (s_last || i_idx == I_LAST) ? LOAD_D : LOAD_I;
            end
            LOAD_D: begin
                cpu_arst_n = 1'b0;
                s_ready    = 1'b1;
                state_nx   = s_valid && (s_last || d_idx == D_LAST) ? SETTLE : LOAD_D;
            end
            SETTLE: begin
                cpu_arst_n = 1'b0;
                state_nx   = run_q != '0 ? RUN : dump_q != '0 ? DUMP_RD : DONE;
            end
            RUN: begin
                cpu_enable = 1'b1;
                if (run_cnt == CNT_W'(1))
                    state_nx = dump_q != '0 ? DUMP_RD : DONE;
            end
            DUMP_RD: begin
                dmem_ren  = 1'b1;
                dmem_addr = 64'({j_idx, 3'b000});
                state_nx  = DUMP_WAIT;
            end
            DUMP_WAIT: state_nx = DUMP_OUT;
            DUMP_OUT: begin
                m_valid = 1'b1;
                if (m_ready)
                    state_nx = dump_cnt + 1'b1 == dump_q ? DONE : DUMP_RD;
            end
            DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = start ? LOAD_I : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            run_q      <= '0;
            dump_q     <= '0;
            run_cnt    <= '0;
            dump_cnt   <= '0;
            i_idx      <= '0;
            d_idx      <= '0;
            j_idx      <= '0;
            ovf_err    <= 1'b0;
            imem_wen   <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_wen   <= 1'b0;
            wr_addr    <= '0;
            dmem_wdata <= '0;
            m_data     <= '0;
        end else begin
            imem_wen <= acc && state == LOAD_I;
            dmem_wen <= acc && state == LOAD_D;
            if (go) begin
                run_q    <= run_cycles;
                dump_q   <= dump_words;
                ovf_err  <= 1'b0;
                i_idx    <= '0;
                d_idx    <= '0;
                j_idx    <= '0;
                dump_cnt <= '0;
            end
            if (ovf_hit)
                ovf_err <= 1'b1;
            if (acc && state == LOAD_I) begin
                imem_addr  <= 64'({i_idx, 2'b00});
                imem_wdata <= s_data[31:0];
                i_idx      <= i_idx + 1'b1;
            end
            if (acc && state == LOAD_D) begin
                wr_addr    <= 64'({d_idx, 3'b000});
                dmem_wdata <= s_data;
                d_idx      <= d_idx + 1'b1;
            end
            if (state == SETTLE)
                run_cnt <= run_q;
            else if (state == RUN)
                run_cnt <= run_cnt - 1'b1;
            // read data arrives one cycle after dmem_ren, i.e. during DUMP_WAIT
            if (state == DUMP_WAIT)
                m_data <= dmem_rdata;
            if (state == DUMP_OUT && m_ready) begin
                dump_cnt <= dump_cnt + 1'b1;
                j_idx    <= j_idx == D_LAST ? '0 : j_idx + 1'b1;
            end
        end
    end
endmodule
